id_exe_elastic: RTL
===================

// Module: id_exe_elastic
// PURPOSE
//  Parametrised ID->EXE pipeline register with valid/ready handshake, 2-entry skid buffer,
//  synchronous flush and stall-cycle counter. Sits between decode and ALU; carries PC, branch
//  target, write address, operands and control bits. Lets EXE back-pressure ID without dropping data.
// PARAMETERS
//  ADDR_W     32  width of pc / branch_addr / write_addr fields
//  DATA_W     32  width of reg1 / reg2 / sw / write operand fields
//  ALUCTRL_W  4   width of ALU control field
//  ALU_NOP    0   ALU control value driven after reset
//  SKID_EN    1   1: registered id_ready with skid entry; 0: single entry, id_ready = !full | exe_ready
//  SCNT_W     16  width of stall counter
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         reset, asynchronous, active-high
//  flush        in   1         synchronous kill of all held entries
//  id_valid     in   1         ID presents a valid bundle
//  id_ready     out  1         block can accept a bundle this cycle
//  id_pc, id_branch_addr, id_write_addr       in  ADDR_W each  address fields
//  id_reg1, id_reg2, id_sw, id_write          in  DATA_W each  operand fields
//  id_aluctrl   in   ALUCTRL_W ALU operation
//  id_lwsrc, id_movsrc, id_reg_write, id_dm_read, id_dm_write  in 1 each  control bits
//  exe_valid    out  1         output bundle valid
//  exe_ready    in   1         EXE consumes bundle this cycle
//  exe_* (pc .. dm_write)      out  same widths as id_*  registered bundle
//  stall_cnt    out  SCNT_W    cycles with exe_valid & !exe_ready, saturating
// BEHAVIOUR
//  Reset: state EMPTY; exe_valid=0, id_ready=1, all exe_* data=0, exe_aluctrl=ALU_NOP,
//   control bits 0, skid entry cleared, stall_cnt=0. No output toggles until first accept.
//  acc = id_valid & id_ready; take = exe_valid & exe_ready. exe_* always driven from main entry.
//  States (SKID_EN=1): EMPTY (no entry), FULL (main), SKID (main+skid); id_ready = (state!=SKID), registered.
//   EMPTY: acc -> FULL, main<=id.
//   FULL : acc&take -> FULL, main<=id; acc&!take -> SKID, skid<=id; !acc&take -> EMPTY; else hold.
//   SKID : take -> FULL, main<=skid; else hold. No accept possible.
//  SKID_EN=0: states EMPTY/FULL only; id_ready combinational = (state==EMPTY)|exe_ready.
//  Latency: accepted bundle appears on exe_* the next cycle when EMPTY/FULL-with-take.
//  Order preserved; no bundle duplicated or dropped except by flush.
//  exe_reg_write, exe_dm_read, exe_dm_write gated to 0 whenever exe_valid=0 (bubble is a NOP);
//   other exe_* fields hold last value when invalid.
//  flush (highest priority): next state EMPTY, both entries invalid, input bundle that cycle discarded
//   even if acc; take that same cycle still counts as consumed by EXE. id_ready=1 next cycle.
//  stall_cnt: +1 each cycle exe_valid&!exe_ready (incl. flush cycle); saturates at 2^SCNT_W-1; reset only clears.
//  rst asserted mid-transfer: immediate return to reset values, in-flight bundles lost.
// TESTING
//  1 Reset then id_valid=1, pc=0x100, exe_ready=1 -> next cycle exe_valid=1, exe_pc=0x100, id_ready=1.
//  2 Stream pc 0x0,0x4,0x8; exe_ready=0 for 2 cycles -> state SKID, id_ready=0, stall_cnt=2; release
//    -> exe_pc sequence 0x0,0x4,0x8 with no loss/duplication.
//  3 SKID state, flush=1 with id_valid=1 -> next cycle exe_valid=0, exe_dm_write=0, id_ready=1, input dropped.
//  4 exe_valid=0 after drain with last bundle dm_write=1 -> exe_dm_write=0, exe_reg_write=0.
//  5 SCNT_W=4, hold exe_ready=0 for 20 cycles with valid bundle -> stall_cnt saturates at 15.
//  6 SKID_EN=0, full, exe_ready=1 & id_valid=1 -> same-cycle accept, throughput 1/cycle; rst mid-stream
//    -> exe_valid=0, exe_aluctrl=ALU_NOP immediately.

Source files
------------

// File: rtl/id_exe_elastic_if.sv
// Decode-to-execute bundle handshake: the producer drives valid and the bundle,
// and the consumer returns ready.
interface id_exe_elastic_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ALUCTRL_W = 4
);
    logic                 valid;
    logic                 ready;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    branch_addr;
    logic [ADDR_W-1:0]    write_addr;
    logic [DATA_W-1:0]    reg1;
    logic [DATA_W-1:0]    reg2;
    logic [DATA_W-1:0]    sw;
    logic [DATA_W-1:0]    write;
    logic [ALUCTRL_W-1:0] aluctrl;
    logic                 lwsrc;
    logic                 movsrc;
    logic                 reg_write;
    logic                 dm_read;
    logic                 dm_write;

    modport master (
        output valid, pc, branch_addr, write_addr, reg1, reg2, sw, write,
               aluctrl, lwsrc, movsrc, reg_write, dm_read, dm_write,
        input  ready
    );

    modport slave (
        input  valid, pc, branch_addr, write_addr, reg1, reg2, sw, write,
               aluctrl, lwsrc, movsrc, reg_write, dm_read, dm_write,
        output ready
    );
endinterface

// File: rtl/id_exe_elastic.sv
// ID->EXE pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall-cycle counter.
module id_exe_elastic #(
    parameter int                   ADDR_W    = 32,
    parameter int                   DATA_W    = 32,
    parameter int                   ALUCTRL_W = 4,
    parameter logic [ALUCTRL_W-1:0] ALU_NOP   = '0,
    parameter bit                   SKID_EN   = 1'b1,
    parameter int                   SCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    id_exe_elastic_if.slave   i_id,
    id_exe_elastic_if.master  o_exe,
    output logic [SCNT_W-1:0] o_stall_cnt
);
    typedef struct packed {
        logic [ADDR_W-1:0]    pc;
        logic [ADDR_W-1:0]    branch_addr;
        logic [ADDR_W-1:0]    write_addr;
        logic [DATA_W-1:0]    reg1;
        logic [DATA_W-1:0]    reg2;
        logic [DATA_W-1:0]    sw;
        logic [DATA_W-1:0]    write;
        logic [ALUCTRL_W-1:0] aluctrl;
        logic                 lwsrc;
        logic                 movsrc;
        logic                 reg_write;
        logic                 dm_read;
        logic                 dm_write;
    } bndl_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            r_state, w_state_nx;
    bndl_t             r_main, r_skid, w_id;
    logic              w_acc, w_take, w_exe_valid;
    logic              w_main_ld, w_main_from_skid, w_skid_ld;
    logic [SCNT_W-1:0] r_stall;

    assign w_id.pc          = i_id.pc;
    assign w_id.branch_addr = i_id.branch_addr;
    assign w_id.write_addr  = i_id.write_addr;
    assign w_id.reg1        = i_id.reg1;
    assign w_id.reg2        = i_id.reg2;
    assign w_id.sw          = i_id.sw;
    assign w_id.write       = i_id.write;
    assign w_id.aluctrl     = i_id.aluctrl;
    assign w_id.lwsrc       = i_id.lwsrc;
    assign w_id.movsrc      = i_id.movsrc;
    assign w_id.reg_write   = i_id.reg_write;
    assign w_id.dm_read     = i_id.dm_read;
    assign w_id.dm_write    = i_id.dm_write;

    assign w_exe_valid = (r_state != ST_EMPTY);
    assign w_take      = w_exe_valid & o_exe.ready;

    // With the skid entry, ready depends only on state so it never forms a
    // combinational path back from EXE to ID.
    generate
        if (SKID_EN) begin : g_skid
            assign i_id.ready = (r_state != ST_SKID);
        end else begin : g_noskid
            assign i_id.ready = (r_state == ST_EMPTY) | o_exe.ready;
        end
    endgenerate

    assign w_acc = i_id.valid & i_id.ready;

    always_comb begin
        w_state_nx       = r_state;
        w_main_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        if (i_flush) begin
            w_state_nx = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nx = ST_FULL;
                        w_main_ld  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_acc && w_take) begin
                        w_main_ld = 1'b1;
                    end else if (w_acc && SKID_EN) begin
                        w_state_nx = ST_SKID;
                        w_skid_ld  = 1'b1;
                    end else if (!w_acc && w_take) begin
                        w_state_nx = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_take) begin
                        w_state_nx       = ST_FULL;
                        w_main_ld        = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nx = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_EMPTY;
            r_main         <= '0;
            r_main.aluctrl <= ALU_NOP;
            r_skid         <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_main_ld) r_main <= w_main_from_skid ? r_skid : w_id;
            if (w_skid_ld) r_skid <= w_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_exe_valid && !o_exe.ready && (r_stall != {SCNT_W{1'b1}})) begin
            r_stall <= r_stall + SCNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall;

    // Side-effecting controls are masked so an empty slot reads as a NOP.
    assign o_exe.valid       = w_exe_valid;
    assign o_exe.pc          = r_main.pc;
    assign o_exe.branch_addr = r_main.branch_addr;
    assign o_exe.write_addr  = r_main.write_addr;
    assign o_exe.reg1        = r_main.reg1;
    assign o_exe.reg2        = r_main.reg2;
    assign o_exe.sw          = r_main.sw;
    assign o_exe.write       = r_main.write;
    assign o_exe.aluctrl     = r_main.aluctrl;
    assign o_exe.lwsrc       = r_main.lwsrc;
    assign o_exe.movsrc      = r_main.movsrc;
    assign o_exe.reg_write   = r_main.reg_write & w_exe_valid;
    assign o_exe.dm_read     = r_main.dm_read & w_exe_valid;
    assign o_exe.dm_write    = r_main.dm_write & w_exe_valid;
endmodule
